// File: rtl/spart_if.sv
// Bus-side handshake between the bus driver and the serial port.
// The 8-bit databus stays a separate inout port on the SPART.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart.sv
// Serial port: register decode, programmable 16x-oversampling baud generator,
// 8N1 transmitter and receiver with a single-byte receive buffer.
module spart (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic        wr, rd;
  logic [7:0]  rdata;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic        div_wr, tick;

  state_e      tx_state_q;
  logic [7:0]  tx_sh_q;
  logic [3:0]  tx_tcnt_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q, tbr_q, tx_wr;

  state_e      rx_state_q;
  logic [7:0]  rx_sh_q, rbuf_q;
  logic [3:0]  rx_tcnt_q;
  logic [2:0]  rx_bit_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_set, rda_q, rd_buf;

  assign wr     = bus.iocs & ~bus.iorw;
  assign rd     = bus.iocs & bus.iorw;
  assign tx_wr  = wr && (bus.ioaddr == 2'b00);
  assign rd_buf = rd && (bus.ioaddr == 2'b00);

  assign bus.rda = rda_q;
  assign bus.tbr = tbr_q;
  assign txd     = txd_q;

  always_comb begin
    rdata = 8'h00;
    unique case (bus.ioaddr)
      2'b00:   rdata = rbuf_q;
      2'b01:   rdata = {6'b0, tbr_q, rda_q};
      default: rdata = 8'h00;
    endcase
  end

  assign databus = rd ? rdata : 8'hzz;

  always_comb begin
    div_d  = div_q;
    div_wr = 1'b0;
    if (wr && bus.ioaddr == 2'b10) begin
      div_d[7:0] = databus;
      div_wr     = 1'b1;
    end
    if (wr && bus.ioaddr == 2'b11) begin
      div_d[15:8] = databus;
      div_wr      = 1'b1;
    end
  end

  // Ticking at cnt <= 1 makes D=0 behave like D=1.
  assign tick = (cnt_q <= 16'd1);

  always_comb begin
    if (div_wr)    cnt_d = div_d;
    else if (tick) cnt_d = div_q;
    else           cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 16'h0145;
      cnt_q <= 16'h0145;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // txd still high in StStart means the first tick has not yet started the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_sh_q    <= 8'h00;
      tx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (tx_wr) begin
            tx_sh_q    <= databus;
            tx_state_q <= StStart;
            tbr_q      <= 1'b0;
          end
        end
        StStart: begin
          if (tick) begin
            if (txd_q) begin
              txd_q     <= 1'b0;
              tx_tcnt_q <= 4'd0;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 4'd1;
              if (tx_tcnt_q == 4'd15) begin
                tx_state_q <= StData;
                txd_q      <= tx_sh_q[0];
                tx_sh_q    <= tx_sh_q >> 1;
                tx_bit_q   <= 3'd0;
              end
            end
          end
        end
        StData: begin
          if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= StStop;
                txd_q      <= 1'b1;
              end else begin
                txd_q    <= tx_sh_q[0];
                tx_sh_q  <= tx_sh_q >> 1;
                tx_bit_q <= tx_bit_q + 3'd1;
              end
            end
          end
        end
        StStop: begin
          if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
              tx_state_q <= StIdle;
              tbr_q      <= 1'b1;
            end
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_set  = (rx_state_q == StStop) && tick && (rx_tcnt_q == 4'd15) && rx_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_sh_q    <= 8'h00;
      rx_tcnt_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rbuf_q     <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      // A new byte beats a simultaneous buffer read.
      if (rx_set)      rda_q <= 1'b1;
      else if (rd_buf) rda_q <= 1'b0;
      unique case (rx_state_q)
        StIdle: begin
          if (rx_fall) begin
            rx_state_q <= StStart;
            rx_tcnt_q  <= 4'd0;
          end
        end
        StStart: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q <= 4'd0;
              rx_bit_q  <= 3'd0;
              rx_state_q <= rx_s2_q ? StIdle : StData;
            end
          end
        end
        StData: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
              rx_bit_q <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              if (rx_s2_q) rbuf_q <= rx_sh_q;
              rx_state_q <= StIdle;
            end
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

endmodule
